divisor_unit: RTL and testbench



---
 rtl/divisor_unit.sv | 132 +++++++++++++
 tb/tb_divisor_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_unit.sv
// divisor_unit: iterative shift-subtract divider, one quotient bit per clock.
// Handles signed (two's complement) and unsigned operands through a
// magnitude datapath, followed by sign correction on completion.
module divisor_unit #(
   parameter int parallelism = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   valid,
   input  logic                   usigned_n,
   input  logic [parallelism-1:0] dividend,
   input  logic [parallelism-1:0] divisor,
   output logic [parallelism-1:0] quotient,
   output logic [parallelism-1:0] reminder,
   output logic                   res_ready
);

   localparam int N  = parallelism;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [N-1:0]    rem_q, rem_d;
   logic [N-1:0]    work_q, work_d;
   logic [N-1:0]    dvs_q, dvs_d;
   logic            q_neg_q, q_neg_d;
   logic            r_neg_q, r_neg_d;
   logic            dz_q, dz_d;
   logic [N-1:0]    quotient_q, quotient_d;
   logic [N-1:0]    reminder_q, reminder_d;
   logic            res_ready_q, res_ready_d;

   logic [N:0]      trial;
   logic            ge;
   logic            dnd_neg;
   logic            dvs_neg;

   // Next-state logic: operand capture, one restoring step per CALC cycle,
   // and sign/zero correction when the result is published.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rem_d       = rem_q;
      work_d      = work_q;
      dvs_d       = dvs_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      dz_d        = dz_q;
      quotient_d  = quotient_q;
      reminder_d  = reminder_q;
      res_ready_d = 1'b0;

      dnd_neg = usigned_n & dividend[N-1];
      dvs_neg = usigned_n & divisor[N-1];

      trial = {rem_q, work_q[N-1]};
      ge    = (trial >= {1'b0, dvs_q});

      case (state_q)
         IDLE: begin
            if (valid) begin
               work_d  = dnd_neg ? -dividend : dividend;
               dvs_d   = dvs_neg ? -divisor : divisor;
               rem_d   = '0;
               count_d = CW'(N);
               q_neg_d = dnd_neg ^ dvs_neg;
               r_neg_d = dnd_neg;
               dz_d    = (divisor == '0);
               state_d = CALC;
            end
         end
         CALC: begin
            if (count_q != '0) begin
               rem_d   = ge ? N'(trial - {1'b0, dvs_q}) : trial[N-1:0];
               work_d  = {work_q[N-2:0], ge};
               count_d = count_q - CW'(1);
            end else begin
               quotient_d  = dz_q ? '1 : (q_neg_q ? -work_q : work_q);
               reminder_d  = r_neg_q ? -rem_q : rem_q;
               res_ready_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; async reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         rem_q       <= '0;
         work_q      <= '0;
         dvs_q       <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         dz_q        <= 1'b0;
         quotient_q  <= '0;
         reminder_q  <= '0;
         res_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rem_q       <= rem_d;
         work_q      <= work_d;
         dvs_q       <= dvs_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         dz_q        <= dz_d;
         quotient_q  <= quotient_d;
         reminder_q  <= reminder_d;
         res_ready_q <= res_ready_d;
      end
   end

   assign quotient  = quotient_q;
   assign reminder  = reminder_q;
   assign res_ready = res_ready_q;

endmodule

// File: tb/tb_divisor_unit.sv
// tb_divisor_unit: directed self-checking bench for divisor_unit (N = 32).
module tb_divisor_unit;

   logic        clk;
   logic        rst_n;
   logic        valid;
   logic        usigned_n;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic [31:0] reminder;
   logic        res_ready;

   int checks;
   int errors;

   divisor_unit #(.parallelism(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid     (valid),
      .usigned_n (usigned_n),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .reminder  (reminder),
      .res_ready (res_ready)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Issue one operation from IDLE and wait (bounded) for its result.
   // lat is the number of edges after acceptance at which res_ready was seen, -1 on timeout.
   task automatic do_op(input logic mode, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] q, output logic [31:0] r);
      repeat (2) @(negedge clk);
      valid     = 1'b1;
      usigned_n = mode;
      dividend  = a;
      divisor   = b;
      @(posedge clk);
      #1;
      valid     = 1'b0;
      usigned_n = ~mode;
      dividend  = $urandom;
      divisor   = $urandom;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (res_ready === 1'b1) begin
            lat = i;
            break;
         end
      end
      q = quotient;
      r = reminder;
   endtask

   task automatic test_reset();
      rst_n     = 1'b1;
      valid     = 1'b0;
      usigned_n = 1'b0;
      dividend  = '0;
      divisor   = '0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (quotient !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_quotient: got %h expected %h", quotient, 32'h0);
      end
      checks++;
      if (reminder !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_reminder: got %h expected %h", reminder, 32'h0);
      end
      checks++;
      if (res_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_res_ready: got %b expected %b", res_ready, 1'b0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_unsigned();
      int lat;
      logic [31:0] q, r;
      do_op(1'b0, 32'h75, 32'hA, lat, q, r);
      checks++;
      if (lat !== 33) begin
         errors++;
         $display("[TB] FAIL unsigned_latency: got %0d expected %0d", lat, 33);
      end
      checks++;
      if (q !== 32'hB) begin
         errors++;
         $display("[TB] FAIL unsigned_quotient: got %h expected %h", q, 32'hB);
      end
      checks++;
      if (r !== 32'h7) begin
         errors++;
         $display("[TB] FAIL unsigned_reminder: got %h expected %h", r, 32'h7);
      end
      @(posedge clk);
      #1;
      checks++;
      if (res_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL pulse_width: got %b expected %b", res_ready, 1'b0);
      end
      checks++;
      if (quotient !== 32'hB) begin
         errors++;
         $display("[TB] FAIL quotient_hold: got %h expected %h", quotient, 32'hB);
      end
   endtask

   task automatic test_signed();
      int lat;
      logic [31:0] q, r;
      // -7 / 2 signed
      do_op(1'b1, 32'hFFFFFFF9, 32'h2, lat, q, r);
      checks++;
      if (q !== 32'hFFFFFFFD || r !== 32'hFFFFFFFF) begin
         errors++;
         $display("[TB] FAIL signed_neg_pos: got q=%h r=%h expected q=%h r=%h", q, r, 32'hFFFFFFFD, 32'hFFFFFFFF);
      end
      // same operands unsigned
      do_op(1'b0, 32'hFFFFFFF9, 32'h2, lat, q, r);
      checks++;
      if (q !== 32'h7FFFFFFC || r !== 32'h1) begin
         errors++;
         $display("[TB] FAIL unsigned_big: got q=%h r=%h expected q=%h r=%h", q, r, 32'h7FFFFFFC, 32'h1);
      end
      // 7 / -2 signed
      do_op(1'b1, 32'h7, 32'hFFFFFFFE, lat, q, r);
      checks++;
      if (q !== 32'hFFFFFFFD || r !== 32'h1) begin
         errors++;
         $display("[TB] FAIL signed_pos_neg: got q=%h r=%h expected q=%h r=%h", q, r, 32'hFFFFFFFD, 32'h1);
      end
      // -7 / -2 signed
      do_op(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, lat, q, r);
      checks++;
      if (q !== 32'h3 || r !== 32'hFFFFFFFF) begin
         errors++;
         $display("[TB] FAIL signed_neg_neg: got q=%h r=%h expected q=%h r=%h", q, r, 32'h3, 32'hFFFFFFFF);
      end
   endtask

   task automatic test_div_zero();
      int lat;
      logic [31:0] q, r;
      do_op(1'b0, 32'h12345678, 32'h0, lat, q, r);
      checks++;
      if (lat !== 33 || q !== 32'hFFFFFFFF || r !== 32'h12345678) begin
         errors++;
         $display("[TB] FAIL divzero_unsigned: got lat=%0d q=%h r=%h expected lat=33 q=%h r=%h", lat, q, r, 32'hFFFFFFFF, 32'h12345678);
      end
      do_op(1'b1, 32'h12345678, 32'h0, lat, q, r);
      checks++;
      if (lat !== 33 || q !== 32'hFFFFFFFF || r !== 32'h12345678) begin
         errors++;
         $display("[TB] FAIL divzero_signed: got lat=%0d q=%h r=%h expected lat=33 q=%h r=%h", lat, q, r, 32'hFFFFFFFF, 32'h12345678);
      end
      do_op(1'b1, 32'hFFFFFFF9, 32'h0, lat, q, r);
      checks++;
      if (q !== 32'hFFFFFFFF || r !== 32'hFFFFFFF9) begin
         errors++;
         $display("[TB] FAIL divzero_signed_neg: got q=%h r=%h expected q=%h r=%h", q, r, 32'hFFFFFFFF, 32'hFFFFFFF9);
      end
   endtask

   task automatic test_overflow();
      int lat;
      logic [31:0] q, r;
      do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, q, r);
      checks++;
      if (q !== 32'h80000000 || r !== 32'h0) begin
         errors++;
         $display("[TB] FAIL signed_overflow: got q=%h r=%h expected q=%h r=%h", q, r, 32'h80000000, 32'h0);
      end
      do_op(1'b0, 32'h80000000, 32'hFFFFFFFF, lat, q, r);
      checks++;
      if (q !== 32'h0 || r !== 32'h80000000) begin
         errors++;
         $display("[TB] FAIL unsigned_min_by_max: got q=%h r=%h expected q=%h r=%h", q, r, 32'h0, 32'h80000000);
      end
   endtask

   task automatic test_back_to_back();
      int pulses;
      int first_edge;
      int second_edge;
      logic [31:0] q1, r1, q2, r2;
      pulses = 0;
      first_edge = -1;
      second_edge = -1;
      q1 = '0; r1 = '0; q2 = '0; r2 = '0;
      repeat (3) @(negedge clk);
      valid     = 1'b1;
      usigned_n = 1'b0;
      dividend  = 32'h75;
      divisor   = 32'hA;
      @(posedge clk);
      for (int i = 1; i <= 80; i++) begin
         @(posedge clk);
         #1;
         if (i == 5) dividend = 32'h64;
         if (i == 69) valid = 1'b0;
         if (res_ready === 1'b1) begin
            pulses++;
            if (pulses == 1) begin
               first_edge = i; q1 = quotient; r1 = reminder;
            end else if (pulses == 2) begin
               second_edge = i; q2 = quotient; r2 = reminder;
            end
         end
      end
      checks++;
      if (pulses !== 2) begin
         errors++;
         $display("[TB] FAIL b2b_pulse_count: got %0d expected %0d", pulses, 2);
      end
      checks++;
      if (first_edge !== 33 || second_edge !== 68) begin
         errors++;
         $display("[TB] FAIL b2b_timing: got %0d,%0d expected 33,68", first_edge, second_edge);
      end
      checks++;
      if (q1 !== 32'hB || r1 !== 32'h7) begin
         errors++;
         $display("[TB] FAIL b2b_first_result: got q=%h r=%h expected q=%h r=%h", q1, r1, 32'hB, 32'h7);
      end
      checks++;
      if (q2 !== 32'hA || r2 !== 32'h0) begin
         errors++;
         $display("[TB] FAIL b2b_second_result: got q=%h r=%h expected q=%h r=%h", q2, r2, 32'hA, 32'h0);
      end
   endtask

   task automatic test_dropped_valid();
      int pulses;
      int edge_seen;
      logic [31:0] q, r;
      pulses = 0;
      edge_seen = -1;
      q = '0; r = '0;
      repeat (3) @(negedge clk);
      valid     = 1'b1;
      usigned_n = 1'b0;
      dividend  = 32'h75;
      divisor   = 32'hA;
      @(posedge clk);
      #1;
      valid = 1'b0;
      for (int i = 1; i <= 45; i++) begin
         @(posedge clk);
         #1;
         if (i == 10) begin
            valid = 1'b1; dividend = 32'h64; divisor = 32'h3;
         end
         if (i == 11) valid = 1'b0;
         if (res_ready === 1'b1) begin
            pulses++;
            edge_seen = i; q = quotient; r = reminder;
         end
      end
      checks++;
      if (pulses !== 1 || edge_seen !== 33) begin
         errors++;
         $display("[TB] FAIL dropped_valid_pulses: got count=%0d edge=%0d expected count=1 edge=33", pulses, edge_seen);
      end
      checks++;
      if (q !== 32'hB || r !== 32'h7) begin
         errors++;
         $display("[TB] FAIL dropped_valid_result: got q=%h r=%h expected q=%h r=%h", q, r, 32'hB, 32'h7);
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      int lat;
      logic [31:0] q, r;
      pulses = 0;
      repeat (3) @(negedge clk);
      valid     = 1'b1;
      usigned_n = 1'b1;
      dividend  = 32'hFFFFFFF9;
      divisor   = 32'h2;
      @(posedge clk);
      #1;
      valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (quotient !== 32'h0 || reminder !== 32'h0 || res_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_outputs: got q=%h r=%h rdy=%b expected q=0 r=0 rdy=0", quotient, reminder, res_ready);
      end
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (i == 5) rst_n = 1'b1;
         if (res_ready === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0 || quotient !== 32'h0) begin
         errors++;
         $display("[TB] FAIL midreset_no_result: got pulses=%0d q=%h expected pulses=0 q=0", pulses, quotient);
      end
      do_op(1'b0, 32'h75, 32'hA, lat, q, r);
      checks++;
      if (lat !== 33 || q !== 32'hB || r !== 32'h7) begin
         errors++;
         $display("[TB] FAIL after_reset_op: got lat=%0d q=%h r=%h expected lat=33 q=%h r=%h", lat, q, r, 32'hB, 32'h7);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_back_to_back();
      test_dropped_valid();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
